pwm_modulator: RTL and testbench

//  Downstream consumer of the multiplier result stream. Takes each valid

---
 rtl/modulator_pkg.sv | 8 +
 rtl/tick_gen.sv | 28 ++
 rtl/pwm_modulator.sv | 81 ++++++++
 tb/tb_pwm_modulator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/modulator_pkg.sv
// Shared sample type for the multiplier -> PWM stream.
package modulator_pkg;

    localparam int unsigned SampleWidth = 8;

    typedef logic [SampleWidth-1:0] sample_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-clock tick every Div clocks (every clock when Div == 1).
module tick_gen #(
    parameter int unsigned Div = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] Last = CntW'(Div - 1);

    logic [CntW-1:0] presc_q, presc_d;

    always_comb begin
        tick_o  = (presc_q == Last);
        presc_d = tick_o ? '0 : presc_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/pwm_modulator.sv
// Turns the sample stream into a PWM level; duty changes only at period wrap.
module pwm_modulator
    import modulator_pkg::*;
#(
    parameter int unsigned Width       = SampleWidth,
    parameter int unsigned PrescaleDiv = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] data_in_i,
    input  logic             data_in_valid_i,
    output logic             modulated_o,
    output logic             period_start_o,
    output logic             overrun_o
);

    logic             tick;
    logic             wrap;
    logic [Width-1:0] cnt_q, cnt_d;
    logic [Width-1:0] duty_q, duty_d;
    logic [Width-1:0] pending_q, pending_d;
    logic             pending_vld_q, pending_vld_d;
    logic             mod_q, mod_d;
    logic             period_start_q, period_start_d;
    logic             overrun_q, overrun_d;

    tick_gen #(
        .Div(PrescaleDiv)
    ) u_tick_gen (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .tick_o(tick)
    );

    always_comb begin
        wrap          = tick && (cnt_q == '1);
        cnt_d         = tick ? cnt_q + 1'b1 : cnt_q;
        duty_d        = duty_q;
        pending_d     = pending_q;
        pending_vld_d = pending_vld_q;

        if (wrap && pending_vld_q) begin
            duty_d        = pending_q;
            pending_vld_d = 1'b0;
        end
        // A sample arriving on the wrap clock becomes the next pending value.
        if (data_in_valid_i) begin
            pending_d     = data_in_i;
            pending_vld_d = 1'b1;
        end

        mod_d          = (cnt_q < duty_q);
        period_start_d = wrap;
        overrun_d      = data_in_valid_i && pending_vld_q && !wrap;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q          <= '0;
            duty_q         <= '0;
            pending_q      <= '0;
            pending_vld_q  <= 1'b0;
            mod_q          <= 1'b0;
            period_start_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            pending_q      <= pending_d;
            pending_vld_q  <= pending_vld_d;
            mod_q          <= mod_d;
            period_start_q <= period_start_d;
            overrun_q      <= overrun_d;
        end
    end

    assign modulated_o    = mod_q;
    assign period_start_o = period_start_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_pwm_modulator.sv
// Bench for pwm_modulator: two instances (PrescaleDiv 1 and 4) fed the same stream.
module tb_pwm_modulator;
    import modulator_pkg::*;

    localparam int unsigned MaxE = 16384;
    localparam int unsigned MaxP = MaxE / 256 + 2;

    logic    clk = 1'b0;
    logic    rst_n;
    sample_t din;
    logic    dvld;
    logic    mod1, ps1, ov1, mod4, ps4, ov4;

    always #5 clk = ~clk;

    pwm_modulator #(
        .Width      (8),
        .PrescaleDiv(1)
    ) u_dut1 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .data_in_i      (din),
        .data_in_valid_i(dvld),
        .modulated_o    (mod1),
        .period_start_o (ps1),
        .overrun_o      (ov1)
    );

    pwm_modulator #(
        .Width      (8),
        .PrescaleDiv(4)
    ) u_dut4 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .data_in_i      (din),
        .data_in_valid_i(dvld),
        .modulated_o    (mod4),
        .period_start_o (ps4),
        .overrun_o      (ov4)
    );

    // Sample log indexed by clock edge since reset release (edge 1 is the first).
    logic        smp_vld  [MaxE];
    sample_t     smp_dat  [MaxE];
    int unsigned duty_tab [2][MaxP];
    int unsigned e;
    int unsigned last_smp;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned div_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < int'(MaxE); k++) smp_vld[k] = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < int'(MaxP); p++) duty_tab[d][p] = 0;
        e        = 0;
        last_smp = 0;
    endtask

    // Duty of a new period = newest sample seen during the previous period
    // (including one arriving on the previous wrap); otherwise it carries over.
    task automatic model_wrap(input int d);
        int unsigned p;
        logic        found;
        p     = 256 * div_of(d);
        found = 1'b0;
        for (int k = int'(e) - 1; !found && k >= int'(e) - int'(p) && k >= 1; k--) begin
            if (smp_vld[k]) begin
                duty_tab[d][e/p] = smp_dat[k];
                found            = 1'b1;
            end
        end
        if (!found) duty_tab[d][e/p] = duty_tab[d][e/p-1];
    endtask

    task automatic check_edge();
        for (int d = 0; d < 2; d++) begin
            int unsigned div, p, cnt_prev, duty_prev, wl;
            logic        exp_ps, exp_mod, exp_ov, pend;
            logic        o_mod, o_ps, o_ov;
            div    = div_of(d);
            p      = 256 * div;
            exp_ps = (e > 0) && (e % p == 0);
            if (exp_ps) model_wrap(d);
            if (e == 0) begin
                exp_mod = 1'b0;
                exp_ov  = 1'b0;
            end else begin
                cnt_prev  = ((e - 1) / div) % 256;
                duty_prev = duty_tab[d][(e-1)/p];
                exp_mod   = (cnt_prev < duty_prev);
                wl        = ((e - 1) / p) * p;
                pend      = (last_smp != 0) && (last_smp >= wl);
                exp_ov    = smp_vld[e] && !exp_ps && pend;
            end
            o_mod = (d == 0) ? mod1 : mod4;
            o_ps  = (d == 0) ? ps1 : ps4;
            o_ov  = (d == 0) ? ov1 : ov4;
            check_eq($sformatf("modulated div%0d edge%0d", div, e), o_mod, exp_mod);
            check_eq($sformatf("period_start div%0d edge%0d", div, e), o_ps, exp_ps);
            check_eq($sformatf("overrun div%0d edge%0d", div, e), o_ov, exp_ov);
        end
        if (smp_vld[e]) last_smp = e;
    endtask

    task automatic step(input logic v, input sample_t d);
        if (e + 1 >= MaxE) begin
            $display("FAIL edge_budget: got %0d, expected below %0d", e + 1, MaxE);
            $fatal(1, "edge budget exhausted");
        end
        din              = d;
        dvld             = v;
        smp_vld[e+1]     = v;
        smp_dat[e+1]     = d;
        @(posedge clk);
        e++;
        @(negedge clk);
        check_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    // Advance until the chosen instance reports a new period (bounded).
    task automatic wait_ps(input int d);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 2100 && !seen; i++) begin
            if ((d == 0) ? ps1 : ps4) seen = 1'b1;
            else step(1'b0, '0);
        end
        check_eq($sformatf("period_start_timeout div%0d", div_of(d)), seen, 1);
    endtask

    task automatic count_high(input int d, input int n, output int unsigned hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b0, '0);
            if ((d == 0) ? mod1 : mod4) hi++;
        end
    endtask

    initial begin
        int unsigned hi;
        din   = '0;
        dvld  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_edge();

        // Idle: outputs low, period_start every period.
        idle(600);

        // Single sample 14: 14 high clocks per 256.
        step(1'b1, 8'd14);
        step(1'b0, '0);
        wait_ps(0);
        count_high(0, 256, hi);
        check_eq("duty14_high_clocks", hi, 14);

        // 0 then 255 in separate periods.
        while ((e + 1) % 256 != 40) step(1'b0, '0);
        step(1'b1, 8'd0);
        idle(256);
        step(1'b1, 8'd255);
        idle(600);

        // 100 then 200 in one period -> overrun, 200 wins.
        while ((e + 1) % 256 != 10) step(1'b0, '0);
        step(1'b1, 8'd100);
        idle(9);
        step(1'b1, 8'd200);
        idle(600);

        // 50 pending, 80 on the wrap clock.
        while ((e + 1) % 256 != 100) step(1'b0, '0);
        step(1'b1, 8'd50);
        while ((e + 1) % 256 != 0) step(1'b0, '0);
        step(1'b1, 8'd80);
        idle(700);

        // Prescaled instance, sample 64: 256 high clocks of 1024.
        step(1'b1, 8'd64);
        step(1'b0, '0);
        wait_ps(1);
        count_high(1, 1024, hi);
        check_eq("div4_duty64_high_clocks", hi, 256);
        idle(100);
        check_eq("div4_mid_high", mod4, 1);

        // Reset mid-period: outputs drop immediately.
        rst_n = 1'b0;
        #1;
        check_eq("reset_mod1", mod1, 0);
        check_eq("reset_mod4", mod4, 0);
        check_eq("reset_ps1", ps1, 0);
        check_eq("reset_ps4", ps4, 0);
        check_eq("reset_ov1", ov1, 0);
        check_eq("reset_ov4", ov4, 0);
        repeat (3) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        check_edge();
        idle(1200);

        // Sparse random samples, then a dense burst to provoke overruns.
        for (int i = 0; i < 5000; i++)
            step(($urandom_range(0, 199) == 0), sample_t'($urandom));
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 2) == 0), sample_t'($urandom));
        idle(1100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
